uart_data_sequencer: RTL and testbench
======================================

Name: uart_data_sequencer

Overview:
- Sequences the UART byte stream into and out of the processing datapath.
- RX side: pops byte pairs from the RX FIFO and assembles them into 11-bit input samples, low byte first (DINL, then DINH), issuing one valid pulse per sample.
- TX side: captures 19-bit results and serialises them into the TX FIFO as three bytes (DOUTL, DOUTM, DOUTH).
- Sits between the UART FIFOs and the algorithm core. It is controlled by CR.en / CR.rst and reports its state to SR.

Parameters:
- RX_TIMEOUT, 50000, clk cycles allowed between a low byte and its high byte before the low byte is discarded (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  CR.en; RX popping enabled when 1
- clr  in  1  CR.rst; synchronous clear of all state and flags, overrides everything except rst_n
- err_clr  in  1  synchronous clear of sticky flags
- rx_fifo_empty  in  1  RX FIFO empty
- rx_fifo_rdata  in  8  RX FIFO head byte, first-word-fall-through
- rx_fifo_rd  out  1  RX pop strobe
- tx_fifo_full  in  1  TX FIFO full
- tx_fifo_wdata  out  8  TX byte
- tx_fifo_wr  out  1  TX push strobe
- din  out  11  assembled input sample
- din_vld  out  1  one-cycle sample valid
- dout  in  19  algorithm result
- dout_vld  in  1  one-cycle result valid
- busy  out  1  RX_HIGH or TX not idle or pending valid
- rx_timeout_err  out  1  sticky: high byte timed out
- tx_overrun_err  out  1  sticky: result dropped

Behaviour:
- Reset (rst_n=0, async) or clr=1 (sync): RX state = RX_LOW, TX state = TX_IDLE, pending cleared, counter cleared. All outputs are 0: din=0, din_vld=0, rx_fifo_rd=0, tx_fifo_wr=0, tx_fifo_wdata=0, flags=0, busy=0.
- RX FSM (RX_LOW, RX_HIGH):
  - rx_fifo_rd is combinational: en & !rx_fifo_empty & !clr. rx_fifo_rdata is sampled in the same cycle.
  - RX_LOW + pop: latch low byte, go to RX_HIGH, counter=0.
  - RX_HIGH + pop: din <= {rx_fifo_rdata[2:0], low}; din_vld=1 on the next cycle for exactly one cycle; go to RX_LOW. Bits [7:3] of the high byte are ignored.
  - RX_HIGH, no pop: counter increments. At counter==RX_TIMEOUT-1: go to RX_LOW, discard low byte, set rx_timeout_err. A pop arriving in that same cycle wins: the sample is completed and no error is raised.
  - en=0: no pops, counter frozen, state held. din holds its last value.
- TX FSM (TX_IDLE, TX_L, TX_M, TX_H) with shift register sr[18:0] and a one-entry pending register.
  - Capture on dout_vld:
    - If TX_IDLE and pending empty: sr <= dout, go to TX_L.
    - Otherwise, if pending is empty: pending <= dout.
    - Otherwise: drop the result and set tx_overrun_err.
  - tx_fifo_wr is combinational: state != TX_IDLE & !tx_fifo_full. No write occurs while full; the state holds.
  - Write contents and transitions:
    - TX_L writes sr[7:0], then goes to TX_M.
    - TX_M writes sr[15:8], then goes to TX_H.
    - TX_H writes {5'b0, sr[18:16]}.
  - On the TX_H write:
    - If pending is valid: sr <= pending, go to TX_L next cycle.
    - Otherwise: go to TX_IDLE.
  - TX_H write with pending valid and dout_vld in the same cycle: pending moves to sr, and the new dout enters pending. No overrun.
  - TX is independent of en and keeps draining.
- busy is registered-state combinational: (RX==RX_HIGH) | (TX!=TX_IDLE) | pending_vld.
- err_clr clears both sticky flags. A set event in the same cycle wins over err_clr.
- clr asserted mid-frame: the partial low byte and any queued results are lost, with no writes in that cycle.

Test Plan:
- Push 0x34, 0xFD into RX with en=1 -> two pops; din=0x534, din_vld high for exactly 1 cycle.
- Apply dout=0x5A3C1 with tx_fifo_full=0 -> TX writes 0xC1, 0xA3, 0x05 on three consecutive cycles; busy drops afterwards.
- Three dout_vld pulses back-to-back, TX FIFO full for 20 cycles -> first result in sr, second in pending, third dropped with tx_overrun_err=1. After release, exactly 6 bytes are written in order.
- RX_TIMEOUT=8: push 0x11, then nothing for 8 cycles -> rx_timeout_err=1 and state returns to RX_LOW. Then push 0x22, 0x01 -> din=0x122.
- en=0 with 2 bytes queued -> no pops. Set en=1 -> sample assembled. Assert clr while in RX_HIGH -> low byte discarded, all outputs return to 0.
- Assert rst_n=0 asynchronously mid TX_M -> outputs return to 0 immediately, no further tx_fifo_wr.

Source files
------------

// File: rtl/uart_data_sequencer_if.sv
// rtl/uart_data_sequencer_if.sv - UART FIFO / algorithm-core signal bundle for the data sequencer
interface uart_data_sequencer_if;
    logic        en;
    logic        clr;
    logic        err_clr;
    logic        rx_fifo_empty;
    logic [7:0]  rx_fifo_rdata;
    logic        rx_fifo_rd;
    logic        tx_fifo_full;
    logic [7:0]  tx_fifo_wdata;
    logic        tx_fifo_wr;
    logic [10:0] din;
    logic        din_vld;
    logic [18:0] dout;
    logic        dout_vld;
    logic        busy;
    logic        rx_timeout_err;
    logic        tx_overrun_err;

    // Sequencer side
    modport master (
        input  en, clr, err_clr,
        input  rx_fifo_empty, rx_fifo_rdata,
        output rx_fifo_rd,
        input  tx_fifo_full,
        output tx_fifo_wdata, tx_fifo_wr,
        output din, din_vld,
        input  dout, dout_vld,
        output busy, rx_timeout_err, tx_overrun_err
    );

    // FIFO / core / register side
    modport slave (
        output en, clr, err_clr,
        output rx_fifo_empty, rx_fifo_rdata,
        input  rx_fifo_rd,
        output tx_fifo_full,
        input  tx_fifo_wdata, tx_fifo_wr,
        input  din, din_vld,
        output dout, dout_vld,
        input  busy, rx_timeout_err, tx_overrun_err
    );
endinterface

// File: rtl/uart_data_sequencer.sv
// rtl/uart_data_sequencer.sv - packs RX bytes into 11-bit samples and splits 19-bit results into TX bytes
module uart_data_sequencer #(
    parameter int RX_TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_data_sequencer_if.master bus
);
    // Counter only needs to reach RX_TIMEOUT-1
    localparam int CW = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RX_TIMEOUT - 1);

    typedef enum logic {
        RX_LOW,
        RX_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_L,
        TX_M,
        TX_H
    } tx_state_t;

    rx_state_t      rx_state;
    logic [7:0]     low_byte;
    logic [CW-1:0]  cnt;

    tx_state_t      tx_state;
    logic [18:0]    sr;
    logic [18:0]    pend;
    logic           pend_vld;

    logic           rx_pop;
    logic           rx_to_evt;
    logic           tx_wr;
    logic           tx_done;
    logic           pend_take;
    logic           take_direct;
    logic           take_pend;
    logic           overrun_evt;

    // Pop whenever enabled and a byte is present; clr blocks the pop so no byte is lost
    assign rx_pop = bus.en & ~bus.rx_fifo_empty & ~bus.clr;
    assign bus.rx_fifo_rd = rx_pop;

    // Low byte waited too long: only counts while enabled and no high byte arrives
    assign rx_to_evt = (rx_state == RX_HIGH) & bus.en & ~rx_pop & (cnt == CNT_LAST);

    // TX push when a frame is in flight and the FIFO has room; clr suppresses it
    assign tx_wr = (tx_state != TX_IDLE) & ~bus.tx_fifo_full & ~bus.clr;
    assign bus.tx_fifo_wr = tx_wr;

    // Last byte of the current frame leaves this cycle
    assign tx_done = tx_wr & (tx_state == TX_H);

    // Pending result moves into the shift register this cycle
    assign pend_take = pend_vld & (tx_done | (tx_state == TX_IDLE));

    // Result classification: straight into sr, into pending, or dropped
    assign take_direct = bus.dout_vld & (tx_state == TX_IDLE) & ~pend_vld;
    assign take_pend   = bus.dout_vld & ~take_direct & (~pend_vld | pend_take);
    assign overrun_evt = bus.dout_vld & ~take_direct & ~take_pend;

    assign bus.busy = (rx_state == RX_HIGH) | (tx_state != TX_IDLE) | pend_vld;

    // Byte mux for the TX FIFO, zero whenever nothing is pushed
    always_comb begin
        bus.tx_fifo_wdata = 8'h00;
        if (tx_wr) begin
            case (tx_state)
                TX_L:    bus.tx_fifo_wdata = sr[7:0];
                TX_M:    bus.tx_fifo_wdata = sr[15:8];
                TX_H:    bus.tx_fifo_wdata = {5'b0, sr[18:16]};
                default: bus.tx_fifo_wdata = 8'h00;
            endcase
        end
    end

    // RX FSM: pair low/high bytes into a sample, discard a stale low byte on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state           <= RX_LOW;
            low_byte           <= 8'h00;
            cnt                <= '0;
            bus.din            <= 11'h000;
            bus.din_vld        <= 1'b0;
            bus.rx_timeout_err <= 1'b0;
        end else if (bus.clr) begin
            rx_state           <= RX_LOW;
            low_byte           <= 8'h00;
            cnt                <= '0;
            bus.din            <= 11'h000;
            bus.din_vld        <= 1'b0;
            bus.rx_timeout_err <= 1'b0;
        end else begin
            bus.din_vld        <= 1'b0;
            bus.rx_timeout_err <= rx_to_evt | (bus.rx_timeout_err & ~bus.err_clr);
            case (rx_state)
                RX_LOW: begin
                    if (rx_pop) begin
                        low_byte <= bus.rx_fifo_rdata;
                        cnt      <= '0;
                        rx_state <= RX_HIGH;
                    end
                end
                RX_HIGH: begin
                    if (rx_pop) begin
                        // Only the low three bits of the high byte are meaningful
                        bus.din     <= {bus.rx_fifo_rdata[2:0], low_byte};
                        bus.din_vld <= 1'b1;
                        rx_state    <= RX_LOW;
                    end else if (rx_to_evt) begin
                        low_byte <= 8'h00;
                        rx_state <= RX_LOW;
                    end else if (bus.en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_LOW;
            endcase
        end
    end

    // TX FSM: shift out sr as three bytes, with one result of look-ahead in pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state           <= TX_IDLE;
            sr                 <= 19'h00000;
            pend               <= 19'h00000;
            pend_vld           <= 1'b0;
            bus.tx_overrun_err <= 1'b0;
        end else if (bus.clr) begin
            tx_state           <= TX_IDLE;
            sr                 <= 19'h00000;
            pend               <= 19'h00000;
            pend_vld           <= 1'b0;
            bus.tx_overrun_err <= 1'b0;
        end else begin
            bus.tx_overrun_err <= overrun_evt | (bus.tx_overrun_err & ~bus.err_clr);

            case (tx_state)
                TX_IDLE: begin
                    if (take_direct) begin
                        sr       <= bus.dout;
                        tx_state <= TX_L;
                    end else if (pend_vld) begin
                        sr       <= pend;
                        tx_state <= TX_L;
                    end
                end
                TX_L: if (tx_wr) tx_state <= TX_M;
                TX_M: if (tx_wr) tx_state <= TX_H;
                TX_H: begin
                    if (tx_wr) begin
                        if (pend_vld) begin
                            sr       <= pend;
                            tx_state <= TX_L;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase

            // A new result may refill pending in the same cycle it drains
            if (take_pend) begin
                pend     <= bus.dout;
                pend_vld <= 1'b1;
            end else if (pend_take) begin
                pend_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_data_sequencer.sv
// tb/tb_uart_data_sequencer.sv - self-checking bench for uart_data_sequencer
module tb_uart_data_sequencer;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_data_sequencer_if sif();

    uart_data_sequencer #(.RX_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          txcyc[$];
    logic [10:0] dinq[$];
    int          cyc = 0;
    int          last_pop = -1;

    bit          model_on = 1'b0;
    logic [18:0] acc[$];
    int          nw = 0;
    int          drops = 0;
    int          wr_full = 0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [10:0] exp_din;
        logic [18:0] res;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_din(input int lim);
        int i = 0;
        while (dinq.size() == 0 && i < lim) begin
            tick(1);
            i++;
        end
        chk("din_arrive", int'(dinq.size() > 0), 1);
    endtask

    task automatic wait_tx(input int n, input int lim);
        int i = 0;
        while (txq.size() < n && i < lim) begin
            tick(1);
            i++;
        end
        chk("tx_arrive", int'(txq.size() >= n), 1);
    endtask

    task automatic pulse_dout(input logic [18:0] v);
        sif.dout = v;
        sif.dout_vld = 1'b1;
        tick(1);
        sif.dout_vld = 1'b0;
    endtask

    // RX FIFO model: first-word-fall-through, pop decided by the strobe seen before the edge
    initial begin
        bit p;
        sif.rx_fifo_empty = 1'b1;
        sif.rx_fifo_rdata = 8'h00;
        forever begin
            @(negedge clk);
            p = sif.rx_fifo_rd;
            @(posedge clk);
            #1;
            if (p && rxq.size() > 0) void'(rxq.pop_front());
            #1;
            sif.rx_fifo_empty = (rxq.size() == 0);
            sif.rx_fifo_rdata = (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    // Observe outputs mid-cycle; reference model decides which results must be emitted
    always @(negedge clk) begin
        int inflight;
        bit comp;
        cyc++;
        if (sif.rx_fifo_rd) last_pop = cyc;
        if (sif.din_vld) dinq.push_back(sif.din);
        if (sif.tx_fifo_wr && sif.tx_fifo_full) wr_full++;
        if (model_on) begin
            inflight = acc.size() - nw / 3;
            comp = sif.tx_fifo_wr && (nw % 3 == 2);
            if (sif.dout_vld) begin
                if (inflight - (comp ? 1 : 0) < 2) acc.push_back(sif.dout);
                else drops++;
            end
            if (sif.tx_fifo_wr) nw++;
        end
        if (sif.tx_fifo_wr) begin
            txq.push_back(sif.tx_fifo_wdata);
            txcyc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[4];
        logic [7:0]  exp6[6];
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [10:0] expd[$];
        int          q;
        int          i;
        int          k;

        vt[0] = '{8'h34, 8'hFD, 11'h534, 19'h5A3C1, 8'hC1, 8'hA3, 8'h05};
        vt[1] = '{8'h00, 8'hF8, 11'h000, 19'h7FFFF, 8'hFF, 8'hFF, 8'h07};
        vt[2] = '{8'hFF, 8'h07, 11'h7FF, 19'h00000, 8'h00, 8'h00, 8'h00};
        vt[3] = '{8'hA5, 8'h5A, 11'h2A5, 19'h12345, 8'h45, 8'h23, 8'h01};
        exp6  = '{8'h11, 8'h11, 8'h01, 8'h22, 8'h22, 8'h02};

        sif.en = 1'b0;
        sif.clr = 1'b0;
        sif.err_clr = 1'b0;
        sif.tx_fifo_full = 1'b0;
        sif.dout = 19'h0;
        sif.dout_vld = 1'b0;

        // Reset state
        tick(3);
        chk("rst_din", int'(sif.din), 0);
        chk("rst_din_vld", int'(sif.din_vld), 0);
        chk("rst_rd", int'(sif.rx_fifo_rd), 0);
        chk("rst_wr", int'(sif.tx_fifo_wr), 0);
        chk("rst_wdata", int'(sif.tx_fifo_wdata), 0);
        chk("rst_rx_to", int'(sif.rx_timeout_err), 0);
        chk("rst_tx_ov", int'(sif.tx_overrun_err), 0);
        chk("rst_busy", int'(sif.busy), 0);
        rst_n = 1'b1;
        sif.en = 1'b1;
        tick(2);

        // Table-driven sample assembly and result serialisation
        for (int v = 0; v < 4; v++) begin
            dinq.delete();
            txq.delete();
            txcyc.delete();
            rxq.push_back(vt[v].lo);
            rxq.push_back(vt[v].hi);
            wait_din(40);
            if (dinq.size() > 0) chk("vec_din", int'(dinq.pop_front()), int'(vt[v].exp_din));
            tick(2);
            chk("vec_din_vld_once", dinq.size(), 0);
            pulse_dout(vt[v].res);
            wait_tx(3, 40);
            tick(3);
            chk("vec_tx_count", txq.size(), 3);
            if (txq.size() >= 3) begin
                chk("vec_b0", int'(txq[0]), int'(vt[v].b0));
                chk("vec_b1", int'(txq[1]), int'(vt[v].b1));
                chk("vec_b2", int'(txq[2]), int'(vt[v].b2));
                chk("vec_tx_consecutive", txcyc[2] - txcyc[0], 2);
            end
            chk("vec_busy_after", int'(sif.busy), 0);
        end

        // Three back-to-back results into a full TX FIFO
        txq.delete();
        sif.tx_fifo_full = 1'b1;
        sif.dout = 19'h11111;
        sif.dout_vld = 1'b1;
        tick(1);
        sif.dout = 19'h22222;
        tick(1);
        sif.dout = 19'h33333;
        tick(1);
        sif.dout_vld = 1'b0;
        tick(17);
        chk("ovr_flag", int'(sif.tx_overrun_err), 1);
        chk("ovr_no_write_full", txq.size(), 0);
        chk("ovr_busy", int'(sif.busy), 1);
        sif.tx_fifo_full = 1'b0;
        wait_tx(6, 40);
        tick(5);
        chk("ovr_count", txq.size(), 6);
        if (txq.size() == 6) begin
            for (int b = 0; b < 6; b++) chk("ovr_byte", int'(txq[b]), int'(exp6[b]));
        end
        sif.err_clr = 1'b1;
        tick(1);
        sif.err_clr = 1'b0;
        chk("ovr_cleared", int'(sif.tx_overrun_err), 0);

        // RX timeout on a lone low byte, then a good sample
        dinq.delete();
        rxq.push_back(8'h11);
        tick(12);
        chk("to_flag", int'(sif.rx_timeout_err), 1);
        chk("to_back_low", int'(sif.busy), 0);
        chk("to_no_sample", dinq.size(), 0);
        rxq.push_back(8'h22);
        rxq.push_back(8'h01);
        wait_din(40);
        if (dinq.size() > 0) chk("to_din", int'(dinq.pop_front()), 11'h122);
        sif.err_clr = 1'b1;
        tick(1);
        sif.err_clr = 1'b0;
        chk("to_cleared", int'(sif.rx_timeout_err), 0);

        // High byte arriving exactly on the timeout cycle completes the sample
        dinq.delete();
        last_pop = -1;
        rxq.push_back(8'h44);
        i = 0;
        while (last_pop < 0 && i < 20) begin
            tick(1);
            i++;
        end
        q = last_pop;
        i = 0;
        while (cyc != q + TO - 1 && i < 40) begin
            @(posedge clk);
            i++;
        end
        #1;
        rxq.push_back(8'h01);
        wait_din(20);
        if (dinq.size() > 0) chk("edge_din", int'(dinq.pop_front()), 11'h144);
        chk("edge_no_err", int'(sif.rx_timeout_err), 0);

        // en=0 holds bytes in the FIFO
        dinq.delete();
        sif.en = 1'b0;
        rxq.push_back(8'h78);
        rxq.push_back(8'h06);
        tick(6);
        chk("en0_no_pop", rxq.size(), 2);
        chk("en0_no_sample", dinq.size(), 0);
        sif.en = 1'b1;
        wait_din(20);
        if (dinq.size() > 0) chk("en1_din", int'(dinq.pop_front()), 11'h678);

        // clr while in RX_HIGH with a TX frame stalled
        txq.delete();
        sif.tx_fifo_full = 1'b1;
        pulse_dout(19'h0ABCD);
        rxq.push_back(8'hAB);
        tick(4);
        chk("clr_busy_before", int'(sif.busy), 1);
        sif.tx_fifo_full = 1'b0;
        sif.clr = 1'b1;
        #1;
        chk("clr_no_wr", int'(sif.tx_fifo_wr), 0);
        @(posedge clk);
        #1;
        sif.clr = 1'b0;
        chk("clr_busy", int'(sif.busy), 0);
        chk("clr_din", int'(sif.din), 0);
        chk("clr_wdata", int'(sif.tx_fifo_wdata), 0);
        tick(5);
        chk("clr_tx_lost", txq.size(), 0);
        dinq.delete();
        rxq.push_back(8'h99);
        rxq.push_back(8'h02);
        wait_din(20);
        if (dinq.size() > 0) chk("clr_low_discarded", int'(dinq.pop_front()), 11'h299);

        // Async reset in the middle of a frame
        txq.delete();
        pulse_dout(19'h5A3C1);
        i = 0;
        while (txq.size() < 1 && i < 20) begin
            tick(1);
            i++;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_wr", int'(sif.tx_fifo_wr), 0);
        chk("arst_busy", int'(sif.busy), 0);
        tick(4);
        chk("arst_tx_stop", txq.size(), 1);
        rst_n = 1'b1;
        tick(2);

        // Randomised traffic against the reference model
        txq.delete();
        acc.delete();
        dinq.delete();
        nw = 0;
        drops = 0;
        wr_full = 0;
        model_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 2 && rxq.size() < 4) begin
                lo = 8'($urandom);
                hi = 8'($urandom);
                rxq.push_back(lo);
                rxq.push_back(hi);
                expd.push_back({hi[2:0], lo});
            end
            sif.en = ($urandom_range(0, 9) < 8);
            sif.tx_fifo_full = ($urandom_range(0, 9) < 3);
            sif.dout = 19'($urandom);
            sif.dout_vld = ($urandom_range(0, 9) < 3);
            tick(1);
        end
        sif.dout_vld = 1'b0;
        sif.tx_fifo_full = 1'b0;
        sif.en = 1'b1;
        i = 0;
        while ((sif.busy || rxq.size() > 0) && i < 300) begin
            tick(1);
            i++;
        end
        tick(3);
        model_on = 1'b0;
        chk("rnd_drained", int'(sif.busy), 0);
        chk("rnd_din_count", dinq.size(), expd.size());
        k = (dinq.size() < expd.size()) ? dinq.size() : expd.size();
        for (int s = 0; s < k; s++) chk("rnd_din", int'(dinq[s]), int'(expd[s]));
        chk("rnd_tx_count", txq.size(), acc.size() * 3);
        k = (txq.size() < acc.size() * 3) ? txq.size() : acc.size() * 3;
        for (int s = 0; s < k; s++) begin
            logic [18:0] r;
            logic [7:0]  eb;
            r = acc[s / 3];
            eb = (s % 3 == 0) ? r[7:0] : ((s % 3 == 1) ? r[15:8] : {5'b0, r[18:16]});
            chk("rnd_tx_byte", int'(txq[s]), int'(eb));
        end
        chk("rnd_overrun", int'(sif.tx_overrun_err), int'(drops > 0));
        chk("rnd_no_wr_full", wr_full, 0);
        chk("rnd_no_timeout", int'(sif.rx_timeout_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
